gate_vector_checker: RTL and testbench
======================================

Name: gate_vector_checker

Overview:
- Self-checking stimulus/response stage for the team's two-input primitive gate cells (AND, OR, NAND, NOR, XOR, XNOR, plus single-input NOT/BUF).
- Upstream of the gate under test, it drives all four input combinations. Downstream of the gate, it samples the gate output and compares it against a built-in reference.
- Reports pass/fail, an error count and a per-vector failure mask. Used in silicon bring-up and on-board gate smoke tests.

Parameters:
- SETTLE_CYCLES, 2, cycles from driving a vector to sampling dut_y; legal range 1..255.
- REPEAT, 1, number of full 4-vector passes per run; legal range 1..255.
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle run request; sampled only in IDLE
- gate_sel  in  3  gate type: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(A), 7 BUF(A); latched on start
- drv_a  out  1  A input to the gate under test
- drv_b  out  1  B input to the gate under test
- dut_y  in  1  output of the gate under test
- busy  out  1  high in SETTLE and SAMPLE
- done  out  1  one-cycle pulse at run end
- pass  out  1  1 when err_count==0 at run end; held until the next start
- err_count  out  CNT_W  mismatches this run; saturates at all-ones
- fail_vec  out  4  bit i set if vector i ({A,B}=i) mismatched in any pass

Behaviour:
- Reset (any time, including mid-run): state=IDLE; all outputs 0; internal vector index, pass counter and settle counter cleared.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 (edge t0):
  - Latch gate_sel; clear err_count and fail_vec; deassert pass.
  - idx=0, pass_cnt=0.
  - {drv_a,drv_b}=00 from t0+1; go to SETTLE.
- SETTLE: hold drv; count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (one cycle):
  - exp = ref(gate_sel_latched, idx[1], idx[0]).
  - If dut_y != exp: err_count++ (saturating) and fail_vec[idx] set.
  - Last vector (idx==3 and pass_cnt==REPEAT-1): go to DONE, drv returns to 00.
  - Otherwise: idx = idx+1 mod 4, pass_cnt increments when idx wraps 3->0; drv updates to the new idx on the same edge; go to SETTLE.
- Vector timing: each vector occupies SETTLE_CYCLES+1 cycles. Vector order is 00, 01, 10, 11 (drv_a = idx[1]).
- DONE (one cycle): done=1; pass=(err_count==0) after including the final sample's result; busy=0; next state IDLE.
- Latency: done is high in cycle t0 + 1 + 4*REPEAT*(SETTLE_CYCLES+1).
- start while busy or in DONE is ignored. Changes to gate_sel mid-run have no effect.
- dut_y is treated as synchronous to clk. Synchronisation of external gate outputs is the caller's responsibility.
- NOT/BUF: the reference uses A only; B is still swept.
- err_count and fail_vec hold their values after done until the next start or reset.

Decomposition:
- Shared package gate_chk_pkg:
  - gate_sel encoding constants (GATE_AND..GATE_BUF)
  - state enum
  - vector count constant NUM_VEC=4
- One sub-module, gate_ref: combinational expected-output model (inputs sel, a, b; output y). It is reused by other gate benches.

Test Plan:
- AND vs. a correct two-input AND, SETTLE=2, REPEAT=1: start -> drv sequence 00,01,10,11 at 3-cycle spacing; done at t0+13; pass=1, err_count=0, fail_vec=0000.
- XOR selected but dut_y tied to an AND output, REPEAT=2 -> mismatches on vectors 1, 2 and 3 in each pass; err_count=6, fail_vec=1110, pass=0; done at t0+25.
- CNT_W=2, dut_y stuck-at-1 with NOR, REPEAT=3 -> raw mismatches 9; err_count saturates at 3; fail_vec=1110; pass=0.
- Assert rst during SETTLE of vector 2 -> next cycle all outputs 0, state IDLE; a fresh start then completes normally with pass=1.
- start pulsed during SAMPLE and gate_sel changed mid-run -> no restart; run completes with the originally latched gate; a single done pulse.
- NOT with a correct inverter on A, B driven randomly -> pass=1; back-to-back start in the cycle after done is accepted.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared constants and state type for the gate vector checker
package gate_chk_pkg;

    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_NAND = 3'd2;
    localparam logic [2:0] GATE_NOR  = 3'd3;
    localparam logic [2:0] GATE_XOR  = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;
    localparam logic [2:0] GATE_NOT  = 3'd6;
    localparam logic [2:0] GATE_BUF  = 3'd7;

    localparam int NUM_VEC = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gate_vector_checker_gate_ref.sv
// rtl/gate_vector_checker_gate_ref.sv - combinational reference model of the primitive gate cells
module gate_ref
    import gate_chk_pkg::*;
(
    input  logic [2:0] sel,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (sel)
            GATE_AND:  y = a & b;
            GATE_OR:   y = a | b;
            GATE_NAND: y = ~(a & b);
            GATE_NOR:  y = ~(a | b);
            GATE_XOR:  y = a ^ b;
            GATE_XNOR: y = ~(a ^ b);
            GATE_NOT:  y = ~a;
            GATE_BUF:  y = a;
            default:   y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - sweeps all input vectors into a gate under test and checks its output
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int REPEAT        = 1,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         gate_sel,
    output logic               drv_a,
    output logic               drv_b,
    input  logic               dut_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_count,
    output logic [NUM_VEC-1:0] fail_vec
);

    state_t     state;
    logic [2:0] sel_q;
    logic [1:0] idx;
    logic [7:0] pass_cnt;
    logic [7:0] settle_cnt;

    logic             exp_y;
    logic             mismatch;
    logic             last_vec;
    logic [1:0]       idx_next;
    logic [CNT_W-1:0] err_next;

    gate_ref u_gate_ref (
        .sel (sel_q),
        .a   (idx[1]),
        .b   (idx[0]),
        .y   (exp_y)
    );

    assign mismatch = (dut_y != exp_y);
    assign last_vec = (idx == 2'd3) && (pass_cnt == 8'(REPEAT - 1));
    assign idx_next = idx + 2'd1;
    // Saturate instead of wrapping so a badly broken gate never reads as a small count.
    assign err_next = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel_q      <= 3'd0;
            idx        <= 2'd0;
            pass_cnt   <= 8'd0;
            settle_cnt <= 8'd0;
            drv_a      <= 1'b0;
            drv_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sel_q      <= gate_sel;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        pass       <= 1'b0;
                        idx        <= 2'd0;
                        pass_cnt   <= 8'd0;
                        settle_cnt <= 8'd0;
                        drv_a      <= 1'b0;
                        drv_b      <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
                        settle_cnt <= 8'd0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch) begin
                        fail_vec[idx] <= 1'b1;
                    end
                    if (last_vec) begin
                        drv_a <= 1'b0;
                        drv_b <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx_next;
                        drv_a <= idx_next[1];
                        drv_b <= idx_next[0];
                        if (idx == 2'd3) begin
                            pass_cnt <= pass_cnt + 8'd1;
                        end
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb/tb_gate_vector_checker.sv - directed self-checking bench for gate_vector_checker
module tb_gate_vector_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] gate_sel = 3'd0;

    logic [1:0] mode_a = 2'd0, mode_b = 2'd0, mode_c = 2'd0;
    logic [2:0] model_sel = 3'd0;

    logic       a_drv_a, a_drv_b, a_y, a_busy, a_done, a_pass;
    logic [7:0] a_err;
    logic [3:0] a_fv;
    logic       b_drv_a, b_drv_b, b_y, b_busy, b_done, b_pass;
    logic [7:0] b_err;
    logic [3:0] b_fv;
    logic       c_drv_a, c_drv_b, c_y, c_busy, c_done, c_pass;
    logic [1:0] c_err;
    logic [3:0] c_fv;

    int checks = 0;
    int errors = 0;
    int done_at_a, done_at_b, done_at_c, done_n_a;
    logic [1:0] hist [0:63];

    always #5 clk = ~clk;

    function automatic logic gold(input logic [2:0] sel, input logic a, input logic b);
        logic [3:0] tt;
        case (sel)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0111;
            3'd3: tt = 4'b0001;
            3'd4: tt = 4'b0110;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        return tt[{a, b}];
    endfunction

    // Gate-under-test behaviours: 0 correct, 1 AND cell, 2 stuck-at-1, 3 inverter on A.
    function automatic logic model_y(input logic [1:0] mode, input logic [2:0] sel,
                                     input logic a, input logic b);
        case (mode)
            2'd0: return gold(sel, a, b);
            2'd1: return a & b;
            2'd2: return 1'b1;
            default: return ~a;
        endcase
    endfunction

    assign a_y = model_y(mode_a, model_sel, a_drv_a, a_drv_b);
    assign b_y = model_y(mode_b, model_sel, b_drv_a, b_drv_b);
    assign c_y = model_y(mode_c, model_sel, c_drv_a, c_drv_b);

    gate_vector_checker #(.SETTLE_CYCLES(2), .REPEAT(1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
        .drv_a(a_drv_a), .drv_b(a_drv_b), .dut_y(a_y), .busy(a_busy), .done(a_done),
        .pass(a_pass), .err_count(a_err), .fail_vec(a_fv)
    );

    gate_vector_checker #(.SETTLE_CYCLES(2), .REPEAT(2), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
        .drv_a(b_drv_a), .drv_b(b_drv_b), .dut_y(b_y), .busy(b_busy), .done(b_done),
        .pass(b_pass), .err_count(b_err), .fail_vec(b_fv)
    );

    gate_vector_checker #(.SETTLE_CYCLES(2), .REPEAT(3), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
        .drv_a(c_drv_a), .drv_b(c_drv_b), .dut_y(c_y), .busy(c_busy), .done(c_done),
        .pass(c_pass), .err_count(c_err), .fail_vec(c_fv)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle t0+ncyc.
    task automatic run(input logic [2:0] sel, input int ncyc, input bit disturb);
        done_at_a = -1; done_at_b = -1; done_at_c = -1; done_n_a = 0;
        gate_sel = sel;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (disturb && k == 3) begin
                start = 1'b1;
                gate_sel = 3'd0;
            end
            if (disturb && k == 4) start = 1'b0;
            if (k < 64) hist[k] = {a_drv_a, a_drv_b};
            if (a_done) begin
                done_n_a++;
                if (done_at_a < 0) done_at_a = k;
            end
            if (b_done && done_at_b < 0) done_at_b = k;
            if (c_done && done_at_c < 0) done_at_c = k;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", a_busy, 0);
        check("reset_drv", {a_drv_a, a_drv_b}, 0);
        check("reset_pass_err_fv", {a_pass, a_done, a_err, a_fv}, 0);
        rst = 1'b0;
        @(negedge clk);

        // AND against a correct AND cell
        model_sel = 3'd0; mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;
        run(3'd0, 45, 1'b0);
        check("and_drv_v0", hist[1], 2'b00);
        check("and_drv_v1", hist[4], 2'b01);
        check("and_drv_v2", hist[7], 2'b10);
        check("and_drv_v3", hist[10], 2'b11);
        check("and_drv_done", hist[13], 2'b00);
        check("and_done_at", done_at_a, 13);
        check("and_done_n", done_n_a, 1);
        check("and_pass", a_pass, 1);
        check("and_err", a_err, 0);
        check("and_fv", a_fv, 0);
        check("and_b_done_at", done_at_b, 25);
        check("and_c_done_at", done_at_c, 37);
        check("and_c_pass", c_pass, 1);

        // XOR selected, AND cell connected
        mode_a = 2'd1; mode_b = 2'd1; mode_c = 2'd1;
        run(3'd4, 45, 1'b0);
        check("xor_a_err", a_err, 3);
        check("xor_b_done_at", done_at_b, 25);
        check("xor_b_err", b_err, 6);
        check("xor_b_fv", b_fv, 4'b1110);
        check("xor_b_pass", b_pass, 0);

        // NOR with a stuck-at-1 output, saturating counter
        mode_a = 2'd2; mode_b = 2'd2; mode_c = 2'd2;
        run(3'd3, 45, 1'b0);
        check("nor_c_done_at", done_at_c, 37);
        check("nor_c_err_sat", c_err, 2'd3);
        check("nor_c_fv", c_fv, 4'b1110);
        check("nor_c_pass", c_pass, 0);
        check("nor_a_err", a_err, 3);

        // Reset during SETTLE of vector 2
        mode_a = 2'd1;
        run(3'd4, 7, 1'b0);
        check("mid_err_before_rst", a_err, 1);
        check("mid_drv_before_rst", {a_drv_a, a_drv_b}, 2'b10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", a_busy, 0);
        check("rst_outputs", {a_drv_a, a_drv_b, a_done, a_pass, a_err, a_fv}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle_busy", a_busy, 0);
        mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0; model_sel = 3'd0;
        run(3'd0, 45, 1'b0);
        check("post_rst_done_at", done_at_a, 13);
        check("post_rst_pass", a_pass, 1);

        // Start pulse during SAMPLE and gate_sel change mid-run
        model_sel = 3'd1;
        run(3'd1, 45, 1'b1);
        check("dist_done_at", done_at_a, 13);
        check("dist_done_n", done_n_a, 1);
        check("dist_pass", a_pass, 1);
        check("dist_err", a_err, 0);
        check("dist_b_pass", b_pass, 1);

        // NOT with an inverter on A, then back-to-back start
        mode_a = 2'd3; mode_b = 2'd3; mode_c = 2'd3;
        run(3'd6, 14, 1'b0);
        check("not_done_at", done_at_a, 13);
        check("not_pass", a_pass, 1);
        check("not_fv", a_fv, 0);
        run(3'd6, 45, 1'b0);
        check("b2b_done_at", done_at_a, 13);
        check("b2b_done_n", done_n_a, 1);
        check("b2b_pass", a_pass, 1);
        check("b2b_c_pass", c_pass, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
